ps2_scancode_rx: RTL and testbench

//  PS/2 keyboard receiver and scan-code-set-2 prefix decoder. Samples the raw PS/2 clock/data

---
 rtl/ps2_scancode_rx_if.sv | 21 ++
 rtl/ps2_scancode_rx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// Key-event bus of the PS/2 receiver: raw PS/2 pins in, decoded scan-code events out.
// master = receiver side, slave = keyboard pins plus event consumer.
interface ps2_scancode_rx_if;
  logic       ps2Ck;
  logic       ps2D;
  logic       strobe;
  logic       pressed;
  logic [7:0] code;
  logic       extended;
  logic       frameErr;

  modport master (
    input  ps2Ck, ps2D,
    output strobe, pressed, code, extended, frameErr
  );

  modport slave (
    output ps2Ck, ps2D,
    input  strobe, pressed, code, extended, frameErr
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver with scan-code-set-2 prefix folding (E0/F0/E1) into key events.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, handing the byte to the decoder
module ps2_scancode_rx #(
  parameter int CLK_HZ     = 56_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 250
) (
  input  logic               clock,
  input  logic               reset,
  ps2_scancode_rx_if.master  kb
);
  localparam int TICK_DIV = CLK_HZ / 1_000_000;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT_US + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    sr, sr_nx;
  logic          byte_ok, err, par_ok;
  logic          ck_s1, ck_s2, d_s1, d_s2, ck_f, ck_f_d, fall, timeout;
  logic [FW-1:0] flt_cnt;
  logic [PW-1:0] pre_cnt;
  logic [TW-1:0] to_cnt;
  logic          ext_f, rel_f;
  logic [2:0]    e1_skip;

  // Lines idle high, so the synchronisers and filter come out of reset at 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_s1   <= 1'b1;
      ck_s2   <= 1'b1;
      d_s1    <= 1'b1;
      d_s2    <= 1'b1;
      ck_f    <= 1'b1;
      ck_f_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      ck_s1  <= kb.ps2Ck;
      ck_s2  <= ck_s1;
      d_s1   <= kb.ps2D;
      d_s2   <= d_s1;
      ck_f_d <= ck_f;
      if (ck_s2 == ck_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        ck_f    <= ck_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall = ck_f_d & ~ck_f;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt <= PW'(TICK_DIV - 1);
      to_cnt  <= TW'(TIMEOUT_US);
    end else if (fall) begin
      pre_cnt <= PW'(TICK_DIV - 1);
      to_cnt  <= TW'(TIMEOUT_US);
    end else if (pre_cnt == '0) begin
      pre_cnt <= PW'(TICK_DIV - 1);
      if (to_cnt != '0) to_cnt <= to_cnt - TW'(1);
    end else begin
      pre_cnt <= pre_cnt - PW'(1);
    end
  end

  assign timeout = (to_cnt == '0) && (state != IDLE) && !fall;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      par_bit <= 1'b0;
    else if (fall && state == PARITY) par_bit <= d_s2;
  end
  assign par_ok = ^{sr, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      sr      <= sr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    sr_nx      = sr;
    byte_ok    = 1'b0;
    err        = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!d_s2) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end else begin
            err = 1'b1;
          end
        end
        DATA: begin
          sr_nx      = {d_s2, sr[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if (d_s2 && par_ok) byte_ok = 1'b1;
          else                err     = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end else if (timeout) begin
      state_nx = IDLE;
      err      = 1'b1;
    end
  end

  // Pause (E1) is followed by 7 bytes that carry no extra information.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kb.strobe   <= 1'b0;
      kb.pressed  <= 1'b0;
      kb.code     <= 8'h00;
      kb.extended <= 1'b0;
      kb.frameErr <= 1'b0;
      ext_f       <= 1'b0;
      rel_f       <= 1'b0;
      e1_skip     <= '0;
    end else begin
      kb.strobe   <= 1'b0;
      kb.frameErr <= err;
      if (byte_ok) begin
        if (e1_skip != '0) begin
          e1_skip <= e1_skip - 3'd1;
        end else begin
          case (sr)
            8'hE1: begin
              e1_skip     <= 3'd7;
              kb.strobe   <= 1'b1;
              kb.code     <= 8'hE1;
              kb.pressed  <= 1'b1;
              kb.extended <= 1'b0;
            end
            8'hE0: ext_f <= 1'b1;
            8'hF0: rel_f <= 1'b1;
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: begin
              ext_f <= 1'b0;
              rel_f <= 1'b0;
            end
            default: begin
              kb.strobe   <= 1'b1;
              kb.code     <= sr;
              kb.pressed  <= ~rel_f;
              kb.extended <= ext_f;
              ext_f       <= 1'b0;
              rel_f       <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: vector table, hand-written corner sequences, random bytes vs model.
module tb_ps2_scancode_rx;
  localparam int FILTER_LEN = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  ps2_scancode_rx_if kb();

  ps2_scancode_rx #(.CLK_HZ(56_000_000), .FILTER_LEN(FILTER_LEN), .TIMEOUT_US(250)) dut (
    .clock(clock),
    .reset(reset),
    .kb(kb)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  ev_t evq[$];
  int  err_cnt = 0;
  int  err_cyc = 0;
  int  strobe_cyc = 0;
  int  last_fall_cyc = 0;
  int  both = 0;
  int  wide = 0;
  logic prev_stb = 1'b0;
  logic prev_err = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (kb.strobe) begin
        evq.push_back('{kb.code, kb.pressed, kb.extended});
        strobe_cyc = cyc;
      end
      if (kb.frameErr) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (kb.strobe && kb.frameErr) both++;
      if ((kb.strobe && prev_stb) || (kb.frameErr && prev_err)) wide++;
      prev_stb = kb.strobe;
      prev_err = kb.frameErr;
    end else begin
      prev_stb = 1'b0;
      prev_err = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      kb.ps2D = bits[i];
      wait_cyc(half);
      kb.ps2Ck = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(half);
      kb.ps2Ck = 1'b1;
    end
    kb.ps2D = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip, input int half);
    send_bits(mk_frame(b, flip), 11, half);
    wait_cyc(25);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         exp_stb;
    logic [7:0] code;
    bit         pressed;
    bit         ext;
    bit         exp_err;
  } vec_t;

  function automatic vec_t mkv(input logic [7:0] b, input bit flip, input bit stb,
                               input logic [7:0] code, input bit pr, input bit ext, input bit er);
    vec_t v;
    v.b = b; v.flip = flip; v.exp_stb = stb; v.code = code;
    v.pressed = pr; v.ext = ext; v.exp_err = er;
    return v;
  endfunction

  vec_t tbl[$];
  bit   m_ext, m_rel;
  int   m_skip;

  initial begin
    kb.ps2Ck = 1'b1;
    kb.ps2D  = 1'b1;
    reset    = 1'b0;
    wait_cyc(5);
    chk("rst_strobe", kb.strobe, 0);
    chk("rst_pressed", kb.pressed, 0);
    chk("rst_code", kb.code, 8'h00);
    chk("rst_extended", kb.extended, 0);
    chk("rst_frameErr", kb.frameErr, 0);
    reset = 1'b1;
    wait_cyc(10);

    tbl.push_back(mkv(8'h1C, 0, 1, 8'h1C, 1, 0, 0));
    tbl.push_back(mkv(8'hF0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h1C, 0, 1, 8'h1C, 0, 0, 0));
    tbl.push_back(mkv(8'hE0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'hF0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h75, 0, 1, 8'h75, 0, 1, 0));
    tbl.push_back(mkv(8'h75, 0, 1, 8'h75, 1, 0, 0));
    if (PAR_EN) tbl.push_back(mkv(8'h1C, 1, 0, 8'h00, 0, 0, 1));
    else        tbl.push_back(mkv(8'h1C, 1, 1, 8'h1C, 1, 0, 0));
    tbl.push_back(mkv(8'hE0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'hFA, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h5A, 0, 1, 8'h5A, 1, 0, 0));
    tbl.push_back(mkv(8'hE1, 0, 1, 8'hE1, 1, 0, 0));
    tbl.push_back(mkv(8'h14, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h77, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'hE1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'hF0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h14, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'hF0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h77, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mkv(8'h16, 0, 1, 8'h16, 1, 0, 0));

    foreach (tbl[i]) begin
      evq.delete();
      err_cnt = 0;
      send_byte(tbl[i].b, tbl[i].flip, 16);
      chk($sformatf("v%0d_strobes", i), evq.size(), tbl[i].exp_stb);
      chk($sformatf("v%0d_frameErr", i), err_cnt, tbl[i].exp_err);
      if (tbl[i].exp_stb && evq.size() != 0) begin
        chk($sformatf("v%0d_code", i), evq[0].code, tbl[i].code);
        chk($sformatf("v%0d_pressed", i), evq[0].pressed, tbl[i].pressed);
        chk($sformatf("v%0d_extended", i), evq[0].ext, tbl[i].ext);
      end
      if (i == 0) chk("latency", strobe_cyc - last_fall_cyc, FILTER_LEN + 3);
    end

    // A clock fall with data high while idle is not a start bit.
    evq.delete(); err_cnt = 0;
    kb.ps2D = 1'b1;
    wait_cyc(5);
    kb.ps2Ck = 1'b0;
    wait_cyc(20);
    kb.ps2Ck = 1'b1;
    wait_cyc(25);
    chk("idle_err_count", err_cnt, 1);
    chk("idle_err_strobes", evq.size(), 0);

    // Short glitch must be filtered out entirely.
    evq.delete(); err_cnt = 0;
    kb.ps2Ck = 1'b0;
    wait_cyc(3);
    kb.ps2Ck = 1'b1;
    wait_cyc(30);
    chk("glitch_err", err_cnt, 0);
    send_byte(8'h1C, 0, 16);
    chk("glitch_strobes", evq.size(), 1);
    if (evq.size() != 0) chk("glitch_code", evq[0].code, 8'h1C);
    chk("glitch_err_after", err_cnt, 0);

    // Frame stalls after 4 data bits.
    evq.delete(); err_cnt = 0;
    send_bits(mk_frame(8'h29, 0), 5, 16);
    for (int k = 0; k < 16800 && err_cnt == 0; k++) wait_cyc(1);
    chk("timeout_err", err_cnt, 1);
    chk("timeout_delay_ok", ((err_cyc - last_fall_cyc) >= 13990) && ((err_cyc - last_fall_cyc) <= 14030), 1);
    chk("timeout_strobes", evq.size(), 0);
    send_byte(8'h29, 0, 16);
    chk("after_timeout_strobes", evq.size(), 1);
    if (evq.size() != 0) chk("after_timeout_code", evq[0].code, 8'h29);
    chk("after_timeout_err", err_cnt, 1);

    // Reset in the middle of a frame, with an E0 pending.
    send_byte(8'hE0, 0, 16);
    evq.delete(); err_cnt = 0;
    send_bits(mk_frame(8'h33, 0), 4, 16);
    reset = 1'b0;
    #2;
    chk("midrst_code", kb.code, 8'h00);
    chk("midrst_strobe", kb.strobe, 0);
    chk("midrst_extended", kb.extended, 0);
    chk("midrst_pressed", kb.pressed, 0);
    kb.ps2Ck = 1'b1;
    kb.ps2D  = 1'b1;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(40);
    chk("midrst_no_strobe", evq.size(), 0);
    chk("midrst_no_err", err_cnt, 0);
    send_byte(8'h16, 0, 16);
    chk("postrst_strobes", evq.size(), 1);
    if (evq.size() != 0) begin
      chk("postrst_code", evq[0].code, 8'h16);
      chk("postrst_ext", evq[0].ext, 0);
      chk("postrst_pressed", evq[0].pressed, 1);
    end

    m_ext = 0; m_rel = 0; m_skip = 0;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b, e_code;
      bit flip, e_stb, e_pr, e_ext, e_err;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: begin
          logic [7:0] drops [7];
          drops = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
          b = drops[$urandom_range(0, 6)];
        end
        3: b = (!m_ext && !m_rel && m_skip == 0) ? 8'hE1 : 8'h1C;
        default: b = 8'($urandom_range(1, 127));
      endcase
      flip = ($urandom_range(0, 7) == 0);
      e_stb = 0; e_err = 0; e_code = b; e_pr = 1; e_ext = 0;
      if (flip && PAR_EN) e_err = 1;
      else if (m_skip != 0) m_skip--;
      else if (b == 8'hE1) begin m_skip = 7; e_stb = 1; end
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}) begin
        m_ext = 0; m_rel = 0;
      end else begin
        e_stb = 1; e_pr = !m_rel; e_ext = m_ext; m_ext = 0; m_rel = 0;
      end
      evq.delete(); err_cnt = 0;
      send_byte(b, flip, $urandom_range(12, 22));
      chk($sformatf("rnd%0d_%02h_strobes", k, b), evq.size(), e_stb);
      chk($sformatf("rnd%0d_%02h_err", k, b), err_cnt, e_err);
      if (e_stb && evq.size() != 0) begin
        chk($sformatf("rnd%0d_code", k), evq[0].code, e_code);
        chk($sformatf("rnd%0d_pressed", k), evq[0].pressed, e_pr);
        chk($sformatf("rnd%0d_extended", k), evq[0].ext, e_ext);
      end
    end

    chk("strobe_frameErr_overlap", both, 0);
    chk("pulse_width_one_cycle", wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
